// File: rtl/cam_capture_px_if.sv
// Signal bundle for cam_capture_px: camera byte stream, crop window configuration and pixel outputs.
interface cam_capture_px_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int FCNT_W = 16
);
  logic              cam_init_done;
  logic              byte_en;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_data;
  logic [1:0]        mode;
  logic [X_W-1:0]    win_x0;
  logic [X_W-1:0]    win_x1;
  logic [Y_W-1:0]    win_y0;
  logic [Y_W-1:0]    win_y1;
  logic [X_W:0]      line_len;
  logic [15:0]       pixel_data;
  logic              pixel_valid;
  logic [X_W-1:0]    pixel_x;
  logic [Y_W-1:0]    pixel_y;
  logic              sof;
  logic              eol;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              line_err;
  logic [7:0]        err_cnt;

  modport master (
    output cam_init_done, byte_en, vsync, href, cam_data, mode,
           win_x0, win_x1, win_y0, win_y1, line_len,
    input  pixel_data, pixel_valid, pixel_x, pixel_y, sof, eol,
           frame_done, frame_cnt, line_err, err_cnt
  );

  modport slave (
    input  cam_init_done, byte_en, vsync, href, cam_data, mode,
           win_x0, win_x1, win_y0, win_y1, line_len,
    output pixel_data, pixel_valid, pixel_x, pixel_y, sof, eol,
           frame_done, frame_cnt, line_err, err_cnt
  );
endinterface

// File: rtl/cam_capture_px.sv
// Frames camera bytes into cropped, tagged pixels (RGB444 / RGB565 / Y-only) with frame counting.
// Optional line-length checking is enabled by defining CAM_CAPTURE_LINE_CHECK_EN.
module cam_capture_px #(
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int FCNT_W     = 16
) (
  input logic             i_clk,
  input logic             i_rstn,
  cam_capture_px_if.slave bus
);
  localparam logic [X_W:0] MAX_X = (X_W+1)'(MAX_WIDTH);
  localparam logic [Y_W:0] MAX_Y = (Y_W+1)'(MAX_HEIGHT);

  typedef enum logic [1:0] {WAIT_INIT, WAIT_VS, VBLANK, ACTIVE} state_t;

  state_t            state, state_next;
  logic              vsync_last, href_last;
  logic              vs_rise, vs_fall, href_fall;
  logic              frame_start, frame_end, line_end, take_byte;
  logic              phase, sof_armed;
  logic [7:0]        b0;
  logic [1:0]        mode;
  logic [X_W-1:0]    x0, x1;
  logic [Y_W-1:0]    y0, y1;
  logic [X_W:0]      raw_x;
  logic [Y_W:0]      raw_y;
  logic              in_win;
  logic [15:0]       fmt;
  logic [15:0]       pixel_data;
  logic              pixel_valid, sof, eol, frame_done;
  logic [X_W-1:0]    pixel_x;
  logic [Y_W-1:0]    pixel_y;
  logic [FCNT_W-1:0] frame_cnt;

  assign vs_rise   = bus.vsync & ~vsync_last;
  assign vs_fall   = ~bus.vsync & vsync_last;
  assign href_fall = ~bus.href & href_last;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= WAIT_INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_INIT: if (bus.cam_init_done) state_next = WAIT_VS;
      WAIT_VS:   if (vs_rise)           state_next = VBLANK;
      VBLANK:    if (vs_fall)           state_next = ACTIVE;
      ACTIVE:    if (vs_rise)           state_next = VBLANK;
      default:                          state_next = WAIT_INIT;
    endcase
  end

  // A vsync rise ends the frame and wins over any byte or line end in the same cycle.
  always_comb begin
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_end    = 1'b0;
    take_byte   = 1'b0;
    case (state)
      VBLANK: frame_start = vs_fall;
      ACTIVE: begin
        frame_end = vs_rise;
        line_end  = href_fall & ~vs_rise;
        take_byte = bus.href & bus.byte_en & ~vs_rise;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_win = ({1'b0, x0} <= raw_x) && (raw_x <= {1'b0, x1}) &&
             ({1'b0, y0} <= raw_y) && (raw_y <= {1'b0, y1});
    case (mode)
      2'd0:    fmt = {4'h0, b0[3:0], bus.cam_data};
      2'd2:    fmt = {8'h00, b0};
      default: fmt = {b0, bus.cam_data};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      vsync_last  <= 1'b0;
      href_last   <= 1'b0;
      phase       <= 1'b0;
      sof_armed   <= 1'b0;
      b0          <= '0;
      mode        <= '0;
      x0          <= '0;
      x1          <= '0;
      y0          <= '0;
      y1          <= '0;
      raw_x       <= '0;
      raw_y       <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vsync_last  <= bus.vsync;
      href_last   <= bus.href;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      frame_done  <= 1'b0;
      if (frame_start) begin
        mode      <= bus.mode;
        x0        <= bus.win_x0;
        x1        <= bus.win_x1;
        y0        <= bus.win_y0;
        y1        <= bus.win_y1;
        raw_x     <= '0;
        raw_y     <= '0;
        phase     <= 1'b0;
        sof_armed <= 1'b1;
      end
      if (frame_end) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
      end
      if (line_end) begin
        raw_x <= '0;
        phase <= 1'b0;
        if (raw_y != MAX_Y) raw_y <= raw_y + 1'b1;
      end else if (take_byte) begin
        if (!phase) begin
          b0    <= bus.cam_data;
          phase <= 1'b1;
        end else begin
          phase <= 1'b0;
          // raw_x parks at MAX_X so overlong lines neither wrap nor emit.
          if (raw_x != MAX_X) begin
            raw_x <= raw_x + 1'b1;
            if (raw_y != MAX_Y && in_win) begin
              pixel_valid <= 1'b1;
              pixel_data  <= fmt;
              pixel_x     <= raw_x[X_W-1:0] - x0;
              pixel_y     <= raw_y[Y_W-1:0] - y0;
              sof         <= sof_armed;
              sof_armed   <= 1'b0;
              eol         <= (raw_x == {1'b0, x1});
            end
          end
        end
      end
    end
  end

`ifdef CAM_CAPTURE_LINE_CHECK_EN
  logic       line_err;
  logic [7:0] err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      line_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      line_err <= 1'b0;
      if (line_end && (raw_x != bus.line_len || phase)) begin
        line_err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign bus.line_err = line_err;
  assign bus.err_cnt  = err_cnt;
`else
  assign bus.line_err = 1'b0;
  assign bus.err_cnt  = 8'h00;
`endif

  assign bus.pixel_data  = pixel_data;
  assign bus.pixel_valid = pixel_valid;
  assign bus.pixel_x     = pixel_x;
  assign bus.pixel_y     = pixel_y;
  assign bus.sof         = sof;
  assign bus.eol         = eol;
  assign bus.frame_done  = frame_done;
  assign bus.frame_cnt   = frame_cnt;
endmodule

// File: tb/tb_cam_capture_px.sv
// Directed bench for cam_capture_px: formats, cropping, overflow, vsync collision, reset and line checks.
`timescale 1ns/1ps
module tb_cam_capture_px;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int FCNT_W = 16;
`ifdef CAM_CAPTURE_LINE_CHECK_EN
  localparam int LC = 1;
`else
  localparam int LC = 0;
`endif

  typedef struct packed {
    logic [15:0]    d;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           sof;
    logic           eol;
  } pix_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cam_capture_px_if #(.X_W(X_W), .Y_W(Y_W), .FCNT_W(FCNT_W)) bus ();

  cam_capture_px #(
    .MAX_WIDTH(640), .MAX_HEIGHT(480), .X_W(X_W), .Y_W(Y_W), .FCNT_W(FCNT_W)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  pix_t              pix_q[$];
  logic [7:0]        tx_q[$];
  int                fd_count = 0;
  int                le_count = 0;
  logic [FCNT_W-1:0] fd_val = '0;
  int                checks = 0;
  int                errors = 0;

  always @(negedge clk) begin
    if (bus.pixel_valid)
      pix_q.push_back(pix_t'({bus.pixel_data, bus.pixel_x, bus.pixel_y, bus.sof, bus.eol}));
    if (bus.frame_done) begin
      fd_count++;
      fd_val = bus.frame_cnt;
    end
    if (bus.line_err) le_count++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired got timeout exp finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_config(input logic [1:0] m, input int xa, input int xb,
                            input int ya, input int yb, input int len);
    bus.mode     = m;
    bus.win_x0   = X_W'(xa);
    bus.win_x1   = X_W'(xb);
    bus.win_y0   = Y_W'(ya);
    bus.win_y1   = Y_W'(yb);
    bus.line_len = (X_W+1)'(len);
  endtask

  // Ends any running frame and starts the next one with the current configuration.
  task automatic vsync_pulse();
    @(negedge clk);
    bus.vsync = 1'b1;
    cycles(3);
    bus.vsync = 1'b0;
    cycles(3);
  endtask

  task automatic send_line();
    @(negedge clk);
    bus.href = 1'b1;
    while (tx_q.size() > 0) begin
      @(negedge clk);
      bus.byte_en  = 1'b1;
      bus.cam_data = tx_q.pop_front();
    end
    @(negedge clk);
    bus.byte_en = 1'b0;
    bus.href    = 1'b0;
    cycles(3);
  endtask

  task automatic test_reset();
    int base, fdb;
    bus.cam_init_done = 1'b0;
    bus.byte_en = 1'b0;
    bus.vsync = 1'b0;
    bus.href = 1'b0;
    bus.cam_data = '0;
    set_config(2'd1, 0, 3, 0, 1, 4);
    rstn = 1'b0;
    cycles(3);
    checks++; if (bus.pixel_valid !== 1'b0 || bus.sof !== 1'b0 || bus.eol !== 1'b0 || bus.frame_done !== 1'b0 || bus.line_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b%b%b%b%b exp 00000", bus.pixel_valid, bus.sof, bus.eol, bus.frame_done, bus.line_err); end
    checks++; if (bus.pixel_data !== 16'h0 || bus.pixel_x !== '0 || bus.pixel_y !== '0) begin errors++; $display("[TB] FAIL reset_pixel got %h/%0d/%0d exp 0/0/0", bus.pixel_data, bus.pixel_x, bus.pixel_y); end
    checks++; if (bus.frame_cnt !== '0 || bus.err_cnt !== 8'h0) begin errors++; $display("[TB] FAIL reset_counts got %0d/%0d exp 0/0", bus.frame_cnt, bus.err_cnt); end
    rstn = 1'b1;
    cycles(2);
    base = pix_q.size();
    fdb  = fd_count;
    vsync_pulse();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_line();
    vsync_pulse();
    checks++; if (pix_q.size() - base !== 0) begin errors++; $display("[TB] FAIL no_init_pixels got %0d exp 0", pix_q.size() - base); end
    checks++; if (fd_count - fdb !== 0) begin errors++; $display("[TB] FAIL no_init_frames got %0d exp 0", fd_count - fdb); end
    bus.cam_init_done = 1'b1;
    cycles(2);
  endtask

  task automatic test_rgb565();
    logic [7:0]  b [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                           8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21};
    logic [15:0] e [8]  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                           16'h0FED, 16'hCBA9, 16'h8765, 16'h4321};
    int base, fdb, leb;
    pix_t p;
    set_config(2'd1, 0, 3, 0, 1, 4);
    vsync_pulse();
    base = pix_q.size();
    fdb  = fd_count;
    leb  = le_count;
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    send_line();
    for (int i = 8; i < 16; i++) tx_q.push_back(b[i]);
    send_line();
    checks++; if (pix_q.size() - base !== 8) begin errors++; $display("[TB] FAIL rgb565_count got %0d exp 8", pix_q.size() - base); end
    if (pix_q.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        p = pix_q[base+i];
        checks++; if (p.d !== e[i]) begin errors++; $display("[TB] FAIL rgb565_data[%0d] got %h exp %h", i, p.d, e[i]); end
        checks++; if (p.x !== X_W'(i % 4) || p.y !== Y_W'(i / 4)) begin errors++; $display("[TB] FAIL rgb565_xy[%0d] got %0d,%0d exp %0d,%0d", i, p.x, p.y, i % 4, i / 4); end
        checks++; if (p.sof !== (i == 0) || p.eol !== (i % 4 == 3)) begin errors++; $display("[TB] FAIL rgb565_tags[%0d] got sof%b eol%b exp sof%b eol%b", i, p.sof, p.eol, i == 0, i % 4 == 3); end
      end
    end
    vsync_pulse();
    checks++; if (fd_count - fdb !== 1) begin errors++; $display("[TB] FAIL rgb565_frame_done got %0d exp 1", fd_count - fdb); end
    checks++; if (fd_val !== 16'd1) begin errors++; $display("[TB] FAIL rgb565_frame_cnt got %0d exp 1", fd_val); end
    checks++; if (le_count - leb !== 0) begin errors++; $display("[TB] FAIL rgb565_line_err got %0d exp 0", le_count - leb); end
  endtask

  task automatic test_formats();
    logic [1:0]  m [3] = '{2'd0, 2'd2, 2'd3};
    logic [7:0]  b [6] = '{8'hAB, 8'hCD, 8'h80, 8'h55, 8'h12, 8'h34};
    logic [15:0] e [3] = '{16'h0BCD, 16'h0080, 16'h1234};
    int base;
    pix_t p;
    for (int k = 0; k < 3; k++) begin
      set_config(m[k], 0, 0, 0, 0, 1);
      vsync_pulse();
      base = pix_q.size();
      tx_q = '{b[2*k], b[2*k+1]};
      send_line();
      checks++; if (pix_q.size() - base !== 1) begin errors++; $display("[TB] FAIL fmt%0d_count got %0d exp 1", k, pix_q.size() - base); end
      if (pix_q.size() - base == 1) begin
        p = pix_q[base];
        checks++; if (p.d !== e[k]) begin errors++; $display("[TB] FAIL fmt%0d_data got %h exp %h", k, p.d, e[k]); end
        checks++; if (p.sof !== 1'b1 || p.eol !== 1'b1) begin errors++; $display("[TB] FAIL fmt%0d_tags got sof%b eol%b exp sof1 eol1", k, p.sof, p.eol); end
      end
    end
  endtask

  task automatic test_window();
    int base, xr, yr;
    pix_t p;
    set_config(2'd1, 2, 5, 1, 2, 8);
    vsync_pulse();
    base = pix_q.size();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        tx_q.push_back(8'(y));
        tx_q.push_back(8'(x));
      end
      send_line();
    end
    checks++; if (pix_q.size() - base !== 8) begin errors++; $display("[TB] FAIL win_count got %0d exp 8", pix_q.size() - base); end
    if (pix_q.size() - base == 8) begin
      checks++; if (pix_q[base].d !== 16'h0102) begin errors++; $display("[TB] FAIL win_first_raw got %h exp 0102", pix_q[base].d); end
      for (int i = 0; i < 8; i++) begin
        p  = pix_q[base+i];
        yr = 1 + i / 4;
        xr = 2 + i % 4;
        checks++; if (p.d !== {8'(yr), 8'(xr)} || p.x !== X_W'(xr - 2) || p.y !== Y_W'(yr - 1)) begin errors++; $display("[TB] FAIL win_pix[%0d] got %h@%0d,%0d exp %h@%0d,%0d", i, p.d, p.x, p.y, {8'(yr), 8'(xr)}, xr - 2, yr - 1); end
        checks++; if (p.sof !== (i == 0) || p.eol !== (xr == 5)) begin errors++; $display("[TB] FAIL win_tags[%0d] got sof%b eol%b exp sof%b eol%b", i, p.sof, p.eol, i == 0, xr == 5); end
      end
    end
  endtask

  task automatic test_overflow();
    int base, leb;
    set_config(2'd2, 0, 1023, 0, 1, 640);
    vsync_pulse();
    base = pix_q.size();
    leb  = le_count;
    for (int i = 0; i < 700; i++) begin
      tx_q.push_back(8'(i));
      tx_q.push_back(8'hAA);
    end
    send_line();
    checks++; if (pix_q.size() - base !== 640) begin errors++; $display("[TB] FAIL ovf_count got %0d exp 640", pix_q.size() - base); end
    if (pix_q.size() - base == 640) begin
      checks++; if (pix_q[base+639].x !== 10'd639 || pix_q[base+639].d !== 16'h007F) begin errors++; $display("[TB] FAIL ovf_last got %h@%0d exp 007f@639", pix_q[base+639].d, pix_q[base+639].x); end
    end
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_line();
    checks++; if (pix_q.size() - base !== 642) begin errors++; $display("[TB] FAIL ovf_next_count got %0d exp 642", pix_q.size() - base); end
    if (pix_q.size() - base == 642) begin
      checks++; if (pix_q[base+640].x !== 10'd0 || pix_q[base+640].y !== 9'd1 || pix_q[base+640].d !== 16'h0011) begin errors++; $display("[TB] FAIL ovf_next_first got %h@%0d,%0d exp 0011@0,1", pix_q[base+640].d, pix_q[base+640].x, pix_q[base+640].y); end
    end
    checks++; if (le_count - leb !== LC) begin errors++; $display("[TB] FAIL ovf_line_err got %0d exp %0d", le_count - leb, LC); end
  endtask

  task automatic test_vsync_collision();
    int base, fdb;
    set_config(2'd1, 0, 3, 0, 0, 4);
    vsync_pulse();
    base = pix_q.size();
    fdb  = fd_count;
    @(negedge clk); bus.href = 1'b1;
    @(negedge clk); bus.byte_en = 1'b1; bus.cam_data = 8'h11;
    @(negedge clk); bus.cam_data = 8'h22;
    @(negedge clk); bus.cam_data = 8'h33;
    @(negedge clk); bus.cam_data = 8'h44; bus.vsync = 1'b1;
    @(negedge clk); bus.byte_en = 1'b0; bus.href = 1'b0;
    cycles(3);
    bus.vsync = 1'b0;
    cycles(3);
    checks++; if (pix_q.size() - base !== 1) begin errors++; $display("[TB] FAIL coll_count got %0d exp 1", pix_q.size() - base); end
    if (pix_q.size() - base == 1) begin
      checks++; if (pix_q[base].d !== 16'h1122) begin errors++; $display("[TB] FAIL coll_data got %h exp 1122", pix_q[base].d); end
    end
    checks++; if (fd_count - fdb !== 1 || fd_val !== 16'd8) begin errors++; $display("[TB] FAIL coll_frame got %0d pulses cnt %0d exp 1 pulses cnt 8", fd_count - fdb, fd_val); end
  endtask

  task automatic test_reset_mid_frame();
    int base, fdb;
    @(negedge clk); bus.href = 1'b1;
    @(negedge clk); bus.byte_en = 1'b1; bus.cam_data = 8'h01;
    @(negedge clk); bus.cam_data = 8'h02;
    @(negedge clk); bus.cam_data = 8'h03;
    @(negedge clk); bus.byte_en = 1'b0; bus.href = 1'b0; bus.cam_init_done = 1'b0; rstn = 1'b0;
    @(negedge clk);
    checks++; if (bus.pixel_valid !== 1'b0 || bus.pixel_data !== 16'h0 || bus.frame_done !== 1'b0 || bus.sof !== 1'b0 || bus.eol !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pixel got v%b %h exp v0 0000", bus.pixel_valid, bus.pixel_data); end
    checks++; if (bus.frame_cnt !== '0 || bus.err_cnt !== 8'h0 || bus.line_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_counts got %0d/%0d exp 0/0", bus.frame_cnt, bus.err_cnt); end
    @(negedge clk); rstn = 1'b1;
    cycles(2);
    base = pix_q.size();
    fdb  = fd_count;
    vsync_pulse();
    tx_q = '{8'h05, 8'h06, 8'h07, 8'h08};
    send_line();
    vsync_pulse();
    checks++; if (pix_q.size() - base !== 0 || fd_count - fdb !== 0) begin errors++; $display("[TB] FAIL midrst_wait_init got %0d pix %0d frames exp 0 0", pix_q.size() - base, fd_count - fdb); end
    bus.cam_init_done = 1'b1;
    cycles(2);
  endtask

  task automatic test_line_check();
    int leb, base;
    set_config(2'd1, 0, 15, 0, 15, 4);
    vsync_pulse();
    leb = le_count;
    tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send_line();
    checks++; if (le_count - leb !== LC || bus.err_cnt !== 8'(LC)) begin errors++; $display("[TB] FAIL lc_short got %0d pulses cnt %0d exp %0d", le_count - leb, bus.err_cnt, LC); end
    tx_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    send_line();
    checks++; if (le_count - leb !== 2 * LC || bus.err_cnt !== 8'(2 * LC)) begin errors++; $display("[TB] FAIL lc_odd got %0d pulses cnt %0d exp %0d", le_count - leb, bus.err_cnt, 2 * LC); end
    base = pix_q.size();
    tx_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send_line();
    checks++; if (le_count - leb !== 2 * LC || bus.err_cnt !== 8'(2 * LC)) begin errors++; $display("[TB] FAIL lc_good got %0d pulses cnt %0d exp %0d", le_count - leb, bus.err_cnt, 2 * LC); end
    checks++; if (pix_q.size() - base !== 4) begin errors++; $display("[TB] FAIL lc_good_count got %0d exp 4", pix_q.size() - base); end
    if (pix_q.size() - base == 4) begin
      checks++; if (pix_q[base].d !== 16'hA0A1 || pix_q[base].x !== 10'd0 || pix_q[base].y !== 9'd2) begin errors++; $display("[TB] FAIL lc_phase_realign got %h@%0d,%0d exp a0a1@0,2", pix_q[base].d, pix_q[base].x, pix_q[base].y); end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_rgb565();
    test_formats();
    test_window();
    test_overflow();
    test_vsync_collision();
    test_reset_mid_frame();
    test_line_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_capture_px.md
Name: cam_capture_px

Overview:
- Parametrised successor to the OV7670 capture block: frames camera bytes into pixels for several output formats.
- Adds crop windowing, frame counting, start-of-frame/end-of-line tagging and overflow protection.
- Sits between the camera pin interface (PCLK edge detector producing a byte strobe) and the frame buffer writer.
- Runs entirely on the system clock domain.

Parameters:
- MAX_WIDTH, 640, maximum raw pixels per line; extra pixels are dropped.
- MAX_HEIGHT, 480, maximum raw lines per frame; extra lines are dropped.
- X_W, 10, width of x coordinates (must hold MAX_WIDTH-1).
- Y_W, 9, width of y coordinates (must hold MAX_HEIGHT-1).
- FCNT_W, 16, width of the frame counter.

Ports:
- i_clk  in  1  system clock (only clock)
- i_rstn  in  1  reset: synchronous, active-low
- i_cam_init_done  in  1  camera register init complete (level)
- i_byte_en  in  1  one-cycle strobe: camera byte valid this cycle (PCLK edge already detected)
- i_vsync  in  1  camera VSYNC, synchronous to i_clk
- i_href  in  1  camera HREF, synchronous to i_clk
- i_cam_data  in  8  camera byte, valid with i_byte_en
- i_mode  in  2  0=RGB444, 1=RGB565, 2=YUV422 Y-only, 3=RGB565
- i_win_x0, i_win_x1  in  X_W each  inclusive crop columns
- i_win_y0, i_win_y1  in  Y_W each  inclusive crop rows
- i_line_len  in  X_W+1  expected raw pixels per line (error check only)
- o_pixel_data  out  16  formatted pixel
- o_pixel_valid  out  1  one-cycle pixel strobe
- o_pixel_x  out  X_W  x relative to i_win_x0
- o_pixel_y  out  Y_W  y relative to i_win_y0
- o_sof  out  1  with o_pixel_valid: first pixel of window
- o_eol  out  1  with o_pixel_valid: pixel at x = i_win_x1
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_frame_cnt  out  FCNT_W  completed frames, wraps
- o_line_err  out  1  one-cycle pulse on bad line
- o_err_cnt  out  8  saturating line-error count

Behaviour:
- Reset: all outputs 0; state WAIT_INIT; byte phase 0; raw x/y 0; mode latch 0.
- Edge detect: vsync and href registered each cycle. Rise = cur & !last; fall = !cur & last.
- FSM:
  - WAIT_INIT -> WAIT_VS when i_cam_init_done = 1.
  - WAIT_VS -> VBLANK on vsync rise.
  - VBLANK -> ACTIVE on vsync fall. On this transition: latch i_mode and window; clear raw x/y, byte phase and sof-armed = 1.
  - ACTIVE -> VBLANK on vsync rise. Same cycle: o_frame_done = 1 and o_frame_cnt += 1.
  - i_cam_init_done is only checked in WAIT_INIT.
- Bytes are accepted only in ACTIVE with i_href = 1 and i_byte_en = 1.
  - Phase 0 stores b0.
  - Phase 1 forms the pixel; phase then toggles back to 0.
- Pixel formats:
  - RGB444: {4'h0, b0[3:0], b1}
  - RGB565: {b0, b1}
  - YUV Y-only: {8'h00, b0}; b1 (chroma) is ignored.
  - Each format yields one pixel per 2 bytes.
- Raw counters:
  - raw x increments per formed pixel and saturates at MAX_WIDTH; pixels formed at raw x = MAX_WIDTH are dropped.
  - On href fall: raw x = 0, raw y += 1 (saturating at MAX_HEIGHT), byte phase = 0.
  - Lines with raw y >= MAX_HEIGHT are dropped.
- Emit rule: o_pixel_valid asserts if x0 <= raw x <= x1 and y0 <= raw y <= y1.
  - Latency: the cycle after the phase-1 byte (registered outputs).
  - o_pixel_x = raw x - x0; o_pixel_y = raw y - y0.
  - o_sof = sof-armed; sof-armed clears after the first emitted pixel.
  - o_eol = (raw x == x1).
- Empty window: if x0 > x1 or y0 > y1, no pixels are emitted and the frame is still counted.
- Simultaneous events:
  - vsync rise with i_byte_en: the byte is dropped and the frame ends.
  - href fall with i_byte_en: the byte is dropped and the line ends.
- Pulse outputs o_pixel_valid, o_sof, o_eol, o_frame_done and o_line_err default to 0 every cycle.
- Reset mid-frame: immediate return to reset state. o_frame_cnt and o_err_cnt clear. A partial frame produces no o_frame_done.

Optional Feature:
- Macro: CAM_CAPTURE_LINE_CHECK_EN.
- Defined: on href fall in ACTIVE, o_line_err pulses (same cycle as raw y increments) when either condition holds:
  - raw pixel count != i_line_len;
  - byte phase = 1 (odd byte count).
  - o_err_cnt increments and saturates at 255.
- Not defined: o_line_err and o_err_cnt are tied 0; the check logic is absent.

Test Plan:
- RGB565, window 0..3 x 0..1, 2 lines of 4 pixels, bytes 0x12,0x34,... -> 8 pixels, first 0x1234 with o_sof = 1, o_eol at x = 3, then o_frame_done with o_frame_cnt = 1.
- RGB444, bytes 0xAB,0xCD -> 0x0BCD. YUV Y-only, bytes 0x80,0x55 -> 0x0080.
- Window x 2..5, y 1..2 on an 8x4 frame -> 8 pixels; first has o_pixel_x = 0, o_pixel_y = 0, o_sof = 1; raw (1,1) is not emitted.
- 700-pixel line with MAX_WIDTH = 640 -> at most 640 pixels; no x wrap; next line starts at raw x = 0.
- vsync rise coincident with i_byte_en mid-line -> no pixel, o_frame_done = 1; i_rstn = 0 mid-frame -> all outputs 0 and the FSM waits for i_cam_init_done.
- With CAM_CAPTURE_LINE_CHECK_EN, i_line_len = 4:
  - a 3-pixel line -> o_line_err pulse, o_err_cnt = 1;
  - a 7-byte line -> o_line_err pulse.
